prbs8_checker: RTL and testbench
================================

Name: prbs8_checker

Overview:
- Receive-side checker for the 8-bit Fibonacci PRBS stream produced by the team's LFSR generator; sits directly downstream of the generator, or after a link or loopback path.
- Self-synchronises to the incoming word stream, then predicts each next word and compares it with what arrives.
- Reports lock status, word-error count and a sticky error flag for link/BIST bring-up.

Parameters:
- LOCK_CNT, 4, consecutive correct predictions in SEARCH required to declare lock (1..15)
- UNLOCK_CNT, 3, consecutive mismatching words in LOCKED that force return to SEARCH (1..15)
- ERR_W, 16, width of the saturating error counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data carries a PRBS word this cycle
- in_data  in  8  received word
- err_clr  in  1  synchronous clear of err_cnt and err_sticky
- locked  out  1  checker is synchronised
- err_cnt  out  ERR_W  mismatching words counted while locked; saturates at all-ones
- err_sticky  out  1  set on any mismatch while locked; held until err_clr or reset
- err_pulse  out  1  one-cycle pulse, registered, for each mismatch while locked

Behaviour:
- Interface (already decided): one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values:
  - locked=0, err_cnt=0, err_sticky=0, err_pulse=0
  - internal predictor=0x00, match/miss counters=0
  - state=SEARCH
- Next-word function: N(d) = {d[6:0], d[0]^d[3]^d[5]^d[6]}, i.e. shift toward the MSB and insert feedback at bit 0.
- All activity is qualified by in_valid. Idle cycles hold all state; err_pulse=0 on idle cycles.
- SEARCH state:
  - Each valid word w is compared with pred.
  - If w==pred and w!=0x00, increment match_cnt; otherwise clear match_cnt.
  - pred <= N(w) on every valid word; the predictor re-seeds from the received data.
  - When match_cnt reaches LOCK_CNT, go to LOCKED. locked=1 is registered the cycle after the LOCK_CNT-th matching word's valid cycle.
  - The first valid word after reset never matches, because pred=0x00 and w=0x00 is excluded.
  - A 0x00 word never counts as a match: it is the generator's lockup state.
- LOCKED state:
  - pred <= N(pred) on each valid word. The predictor free-runs, so a corrupted word does not corrupt the prediction.
  - If w!=pred:
    - err_pulse=1 on the next cycle
    - err_sticky=1
    - err_cnt increments, holding at 2^ERR_W-1
    - miss_cnt increments
  - If w==pred: miss_cnt=0.
  - When miss_cnt reaches UNLOCK_CNT, go to SEARCH: locked=0 the next cycle, match_cnt=0, pred <= N(w).
  - The word that causes unlock is still counted as an error.
- err_clr:
  - Clears err_cnt and err_sticky on the next edge.
  - If err_clr coincides with a mismatch, the clear wins for err_sticky. err_cnt becomes 1; the error is not lost.
  - err_clr does not affect lock state.
- Reset mid-stream: all state returns to reset values immediately (asynchronous). Re-lock needs LOCK_CNT+1 valid words.
- Latency: every output is registered, one cycle after the causing valid word.

Optional Feature:
- Macro PRBS8_CHECKER_BITCNT_EN.
- When defined:
  - Adds output bit_err_cnt [ERR_W-1:0], which accumulates popcount(w^pred) for each valid word while locked.
  - Saturating; cleared by err_clr and reset; updated at the same edge as err_cnt.
- When undefined: the port and its logic are absent, and the remaining behaviour is identical.

Test Plan:
- Generator seeded 0x8A (stream 0x8A, 0x15, 0x2B, 0x57, ...), in_valid=1 continuously, LOCK_CNT=4 -> locked rises 1 cycle after the 5th valid word (0x57's successor); err_cnt stays 0.
- Locked, single word 0x2B replaced by 0x2A -> err_pulse is one cycle; err_cnt=1; err_sticky=1; locked stays 1; following words match (no error propagation); with BITCNT_EN, bit_err_cnt=1.
- Locked, 3 consecutive words forced to 0xFF -> err_cnt=3; locked falls the cycle after the 3rd; re-lock after 5 further good words.
- Constant 0x00 input for 20 valid words -> locked never asserts; err_cnt=0.
- in_valid toggling 1,0,1,0 over a good stream -> lock takes the same number of valid words; no err_pulse on idle cycles.
- err_cnt driven to all-ones (ERR_W=4, 16+ errors) -> holds 0xF. err_clr together with a mismatch -> err_cnt=1 and err_sticky=0 next cycle. Reset asserted mid-lock -> locked=0 and counters=0 asynchronously.

Source files
------------

// File: rtl/prbs8_checker.sv
// prbs8_checker: self-synchronising receive checker for the 8-bit Fibonacci PRBS.
// Define PRBS8_CHECKER_BITCNT_EN to add the saturating bit_err_cnt output.
module prbs8_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             err_clr,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_sticky,
`ifdef PRBS8_CHECKER_BITCNT_EN
    output logic [ERR_W-1:0] bit_err_cnt,
`endif
    output logic             err_pulse
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);
    localparam logic [ERR_W-1:0] ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [7:0]       pred_q, pred_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_sticky_q, err_sticky_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_base;
    logic             hit;
    logic             miss;

    function automatic logic [7:0] prbs_next(input logic [7:0] d);
        return {d[6:0], d[0] ^ d[3] ^ d[5] ^ d[6]};
    endfunction

    assign hit  = (in_data == pred_q);
    assign miss = in_valid && (state_q == LOCKED) && !hit;

    always_comb begin
        state_d      = state_q;
        pred_d       = pred_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        // A clear on the same edge as a miss still keeps that miss.
        err_base     = err_clr ? '0 : err_cnt_q;
        err_cnt_d    = err_base;
        if (miss && (err_base != '1)) begin
            err_cnt_d = err_base + ONE;
        end
        err_sticky_d = !err_clr && (err_sticky_q || miss);
        err_pulse_d  = miss;
        if (in_valid) begin
            unique case (state_q)
                SEARCH: begin
                    pred_d = prbs_next(in_data);
                    if (hit && (in_data != 8'h00)) begin
                        if (match_cnt_q + 4'd1 >= LOCK_N) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 4'd1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    pred_d = prbs_next(pred_q);
                    if (!hit) begin
                        if (miss_cnt_q + 4'd1 >= UNLOCK_N) begin
                            state_d     = SEARCH;
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                            pred_d      = prbs_next(in_data);
                        end else begin
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SEARCH;
            pred_q       <= 8'h00;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            locked_q     <= 1'b0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pred_q       <= pred_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign locked     = locked_q;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;
    assign err_pulse  = err_pulse_q;

`ifdef PRBS8_CHECKER_BITCNT_EN
    logic [ERR_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [ERR_W:0]   bit_sum;
    logic [3:0]       pop;

    always_comb begin
        pop = 4'd0;
        if (in_valid && (state_q == LOCKED)) begin
            for (int i = 0; i < 8; i++) begin
                pop = pop + {3'b000, in_data[i] ^ pred_q[i]};
            end
        end
        bit_sum   = {1'b0, (err_clr ? '0 : bit_cnt_q)}
                  + {{(ERR_W-3){1'b0}}, pop};
        bit_cnt_d = bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_err_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: vector table plus scoreboarded sequences for prbs8_checker.
// Runs with ERR_W=4 so counter saturation is reachable quickly.
module tb_prbs8_checker;

    localparam int ERR_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             err_clr;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;
    logic             err_sticky;
    logic             err_pulse;
`ifdef PRBS8_CHECKER_BITCNT_EN
    logic [ERR_W-1:0] bit_err_cnt;
`endif

    prbs8_checker #(
        .LOCK_CNT  (4),
        .UNLOCK_CNT(3),
        .ERR_W     (ERR_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .err_clr    (err_clr),
        .locked     (locked),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky),
`ifdef PRBS8_CHECKER_BITCNT_EN
        .bit_err_cnt(bit_err_cnt),
`endif
        .err_pulse  (err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       clr;
        logic       lk;
        logic [3:0] cnt;
        logic       st;
        logic       pl;
    } vec_t;

    typedef struct {
        logic       lk;
        logic [3:0] cnt;
        logic       st;
        logic       pl;
        logic [3:0] bits;
        string      nm;
    } exp_t;

    exp_t       sb[$];
    vec_t       tbl[8];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_bits = 4'd0;
    logic [7:0] sv;

    function automatic logic [7:0] nxt(input logic [7:0] d);
        return {d[6:0], d[0] ^ d[3] ^ d[5] ^ d[6]};
    endfunction

    function automatic void add_bits(input int p);
        int s;
        s = int'(exp_bits) + p;
        exp_bits = (s > 15) ? 4'd15 : 4'(s);
    endfunction

    task automatic check(input exp_t e);
        logic bits_ok;
        bits_ok = 1'b1;
`ifdef PRBS8_CHECKER_BITCNT_EN
        bits_ok = (bit_err_cnt === e.bits);
`endif
        checks++;
        if (locked !== e.lk || err_cnt !== e.cnt || err_sticky !== e.st ||
            err_pulse !== e.pl || !bits_ok) begin
            errors++;
            $display("FAIL %s: got lk=%0b cnt=%0d st=%0b pl=%0b, want lk=%0b cnt=%0d st=%0b pl=%0b bits=%0d",
                     e.nm, locked, err_cnt, err_sticky, err_pulse,
                     e.lk, e.cnt, e.st, e.pl, e.bits);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic clr,
                        input logic lk, input logic [3:0] cnt, input logic st,
                        input logic pl, input string nm);
        exp_t e;
        e.lk = lk; e.cnt = cnt; e.st = st; e.pl = pl;
        e.bits = exp_bits; e.nm = nm;
        sb.push_back(e);
        in_valid = v;
        in_data  = d;
        err_clr  = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        e = sb.pop_front();
        check(e);
    endtask

    task automatic good(input logic lk, input logic [3:0] cnt, input logic st,
                        input string nm);
        step(1'b1, sv, 1'b0, lk, cnt, st, 1'b0, nm);
        sv = nxt(sv);
    endtask

    initial begin
        exp_t e;
        int   la;

        tbl[0] = '{1'b1, 8'h8A, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h15, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h2B, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h57, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'hAE, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'h5C, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h55, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 8'hB8, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, "reset_state"};
        check(e);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].lk, tbl[i].cnt,
                 tbl[i].st, tbl[i].pl, $sformatf("tbl%0d", i));
        end
        sv = nxt(8'hB8);
        repeat (3) good(1'b1, 4'd0, 1'b0, "lock_run");

        // single-bit corruption while locked
        add_bits(1);
        step(1'b1, sv ^ 8'h01, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, "flip");
        sv = nxt(sv);
        repeat (3) good(1'b1, 4'd1, 1'b1, "after_flip");

        exp_bits = 4'd0;
        step(1'b1, sv, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "clr_good");
        sv = nxt(sv);

        // three 0xFF words force unlock
        for (int i = 0; i < 3; i++) begin
            add_bits($countones(8'hFF ^ sv));
            step(1'b1, 8'hFF, 1'b0, (i < 2), 4'(i + 1), 1'b1, 1'b1, "ff_burst");
            sv = nxt(sv);
        end
        la = (sv == 8'hFE) ? 3 : 4;
        for (int j = 0; j < 6; j++) begin
            good((j >= la), 4'd3, 1'b1, "relock");
        end

        // saturation of err_cnt at 0xF
        exp_bits = 4'd0;
        step(1'b1, sv, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "clr2");
        sv = nxt(sv);
        for (int i = 1; i <= 17; i++) begin
            add_bits(1);
            step(1'b1, sv ^ 8'h80, 1'b0, 1'b1, 4'((i > 15) ? 15 : i), 1'b1, 1'b1,
                 "sat_bad");
            sv = nxt(sv);
            good(1'b1, 4'((i > 15) ? 15 : i), 1'b1, "sat_good");
        end

        exp_bits = 4'd0;
        add_bits(1);
        step(1'b1, sv ^ 8'h01, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, "clr_with_miss");
        sv = nxt(sv);
        good(1'b1, 4'd1, 1'b0, "post_clr");
        step(1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, "idle_locked");
        good(1'b1, 4'd1, 1'b0, "after_idle");

        // asynchronous reset in mid-cycle
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_bits = 4'd0;
        e = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, "async_reset"};
        check(e);
        #2;
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "zeros");
        end

        sv = 8'h8A;
        for (int i = 0; i < 8; i++) begin
            good((i >= 4), 4'd0, 1'b0, "toggle_valid");
            step(1'b0, 8'hA5, 1'b0, (i >= 4), 4'd0, 1'b0, 1'b0, "toggle_idle");
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
